// File: rtl/decode_round_scheduler_pkg.sv
// Shared definitions for the decode round scheduler: root-stage encodings
// and the scheduler FSM state type.
package decode_round_scheduler_pkg;

  // Root stage controller stage encoding (shared with parent_controller)
  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE   = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_DECODE = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE  = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_FINISH = 3'd3;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_REPORT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/decode_round_scheduler_watchdog.sv
// Decode watchdog: cycles since launch, saturating at TIMEOUT_CYCLES.
// Expire is asserted once the count reaches TIMEOUT_CYCLES-1.
module decode_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_count;

  // Count enabled cycles since the last clear; hold at WD_MAX instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != WD_MAX)) begin
      r_count <= r_count + WD_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expire = (r_count >= WD_LAST);

endmodule

// File: rtl/decode_round_scheduler.sv
// Decode round scheduler: buffers round credits from the syndrome source,
// launches one decode at a time on the root controller, supervises it with
// a watchdog and emits one result record per round on a valid/ready port.
module decode_round_scheduler
  import decode_round_scheduler_pkg::*;
#(
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int QUEUE_DEPTH             = 4,
  parameter int ROUND_ID_WIDTH          = 16,
  parameter int TIMEOUT_CYCLES          = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 round_valid,
  output logic                                 round_ready,
  output logic                                 new_round_start,
  input  logic [STAGE_WIDTH-1:0]               global_stage,
  input  logic                                 result_valid,
  input  logic [ITERATION_COUNTER_WIDTH-1:0]   iteration_counter,
  input  logic [31:0]                          cycle_counter,
  output logic                                 report_valid,
  input  logic                                 report_ready,
  output logic [ROUND_ID_WIDTH-1:0]            report_round_id,
  output logic [ITERATION_COUNTER_WIDTH-1:0]   report_iterations,
  output logic [31:0]                          report_cycles,
  output logic                                 report_timeout,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     pending_count
);

  localparam int PW = $clog2(QUEUE_DEPTH + 1);

  sched_state_e                         r_state;
  logic [PW-1:0]                        r_pending;
  logic                                 r_result_valid_q;
  logic                                 r_new_round_start;
  logic                                 r_report_valid;
  logic                                 r_report_timeout;
  logic [ROUND_ID_WIDTH-1:0]            r_round_id;
  logic [ITERATION_COUNTER_WIDTH-1:0]   r_report_iterations;
  logic [31:0]                          r_report_cycles;

  logic w_accept;
  logic w_report_hs;
  logic w_result_rise;
  logic w_launch;
  logic w_wd_enable;
  logic w_wd_expire;

  assign round_ready   = (r_pending < PW'(QUEUE_DEPTH));
  assign w_accept      = round_valid & round_ready;
  assign w_report_hs   = r_report_valid & report_ready;
  assign w_result_rise = result_valid & ~r_result_valid_q;
  // A launch needs a buffered round and an idle root; a root still busy
  // with a timed-out round blocks the next launch here.
  assign w_launch      = (r_state == S_IDLE) && (r_pending != '0) && (global_stage == STAGE_IDLE);
  assign w_wd_enable   = (r_state == S_LAUNCH) || (r_state == S_WAIT);

  decode_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_launch),
    .i_enable (w_wd_enable),
    .o_expire (w_wd_expire)
  );

  // Rounds accepted but not yet reported; simultaneous accept and report cancel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_accept && !w_report_hs) begin
      r_pending <= r_pending + PW'(1);
    end else if (!w_accept && w_report_hs && (r_pending != '0)) begin
      r_pending <= r_pending - PW'(1);
    end else begin
      r_pending <= r_pending;
    end
  end

  // Delayed result_valid for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_valid_q <= 1'b0;
    end else begin
      r_result_valid_q <= result_valid;
    end
  end

  // Scheduler FSM: launch, wait for result or watchdog, hold record until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= S_IDLE;
      r_new_round_start   <= 1'b0;
      r_report_valid      <= 1'b0;
      r_report_timeout    <= 1'b0;
      r_round_id          <= '0;
      r_report_iterations <= '0;
      r_report_cycles     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_new_round_start <= 1'b1;
            r_state           <= S_LAUNCH;
          end else begin
            r_new_round_start <= 1'b0;
          end
        end
        S_LAUNCH: begin
          r_new_round_start <= 1'b0;
          // A root that never leaves IDLE is also caught by the watchdog
          if (w_wd_expire) begin
            r_report_iterations <= iteration_counter;
            r_report_cycles     <= cycle_counter;
            r_report_timeout    <= 1'b1;
            r_report_valid      <= 1'b1;
            r_state             <= S_REPORT;
          end else if (global_stage != STAGE_IDLE) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_LAUNCH;
          end
        end
        S_WAIT: begin
          // A real result takes priority over a watchdog expiry in the same cycle
          if (w_result_rise) begin
            r_report_iterations <= iteration_counter;
            r_report_cycles     <= cycle_counter;
            r_report_timeout    <= 1'b0;
            r_report_valid      <= 1'b1;
            r_state             <= S_REPORT;
          end else if (w_wd_expire) begin
            r_report_iterations <= iteration_counter;
            r_report_cycles     <= cycle_counter;
            r_report_timeout    <= 1'b1;
            r_report_valid      <= 1'b1;
            r_state             <= S_REPORT;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_REPORT: begin
          if (report_ready) begin
            r_report_valid <= 1'b0;
            r_round_id     <= r_round_id + ROUND_ID_WIDTH'(1);
            r_state        <= S_IDLE;
          end else begin
            r_state <= S_REPORT;
          end
        end
        default: begin
          r_state           <= S_IDLE;
          r_new_round_start <= 1'b0;
          r_report_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign new_round_start   = r_new_round_start;
  assign report_valid      = r_report_valid;
  assign report_timeout    = r_report_timeout;
  assign report_round_id   = r_round_id;
  assign report_iterations = r_report_iterations;
  assign report_cycles     = r_report_cycles;
  assign pending_count     = r_pending;

endmodule

// File: tb/tb_decode_round_scheduler.sv
// Directed bench for decode_round_scheduler with a hand-driven root model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_decode_round_scheduler;
  import decode_round_scheduler_pkg::*;

  localparam int ITW = 8;
  localparam int QD  = 4;
  localparam int IDW = 2;
  localparam int TO  = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   round_valid;
  logic                   round_ready;
  logic                   new_round_start;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic [ITW-1:0]         iteration_counter;
  logic [31:0]            cycle_counter;
  logic                   report_valid;
  logic                   report_ready;
  logic [IDW-1:0]         report_round_id;
  logic [ITW-1:0]         report_iterations;
  logic [31:0]            report_cycles;
  logic                   report_timeout;
  logic [2:0]             pending_count;

  int n_checks = 0;
  int n_errors = 0;

  decode_round_scheduler #(
    .ITERATION_COUNTER_WIDTH (ITW),
    .QUEUE_DEPTH             (QD),
    .ROUND_ID_WIDTH          (IDW),
    .TIMEOUT_CYCLES          (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .round_valid       (round_valid),
    .round_ready       (round_ready),
    .new_round_start   (new_round_start),
    .global_stage      (global_stage),
    .result_valid      (result_valid),
    .iteration_counter (iteration_counter),
    .cycle_counter     (cycle_counter),
    .report_valid      (report_valid),
    .report_ready      (report_ready),
    .report_round_id   (report_round_id),
    .report_iterations (report_iterations),
    .report_cycles     (report_cycles),
    .report_timeout    (report_timeout),
    .pending_count     (pending_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_round();
    round_valid = 1'b1;
    tick();
    round_valid = 1'b0;
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!new_round_start && n < 200) begin
      tick();
      n++;
    end
    check_val("launch_seen", new_round_start, 1);
  endtask

  // Root finishes lat cycles after going busy, presenting the given counters
  task automatic root_finish(input int lat, input logic [ITW-1:0] it, input logic [31:0] cy);
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    repeat (lat) tick();
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = it;
    cycle_counter     = cy;
  endtask

  task automatic root_serve(input int lat, input logic [ITW-1:0] it, input logic [31:0] cy);
    wait_launch();
    root_finish(lat, it, cy);
  endtask

  task automatic take_report(input logic [IDW-1:0] id, input logic [ITW-1:0] it,
                             input logic [31:0] cy, input logic to);
    int n = 0;
    while (!report_valid && n < 300) begin
      tick();
      n++;
    end
    check_val("rpt_valid", report_valid, 1);
    check_val("rpt_id", report_round_id, id);
    check_val("rpt_iter", report_iterations, it);
    check_val("rpt_cyc", report_cycles, cy);
    check_val("rpt_timeout", report_timeout, to);
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    check_val("rpt_dropped", report_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic held;
    logic saw;
    reset             = 1'b1;
    round_valid       = 1'b0;
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b0;
    iteration_counter = '0;
    cycle_counter     = 32'd0;
    report_ready      = 1'b0;
    tick();
    tick();
    // Reset state
    check_val("rst_nrs", new_round_start, 0);
    check_val("rst_rv", report_valid, 0);
    check_val("rst_to", report_timeout, 0);
    check_val("rst_id", report_round_id, 0);
    check_val("rst_iter", report_iterations, 0);
    check_val("rst_cyc", report_cycles, 0);
    check_val("rst_pend", pending_count, 0);
    check_val("rst_ready", round_ready, 1);
    reset = 1'b0;
    tick();

    // 1: single round, launch latency and one-cycle pulse
    pulse_round();
    check_val("t1_pend1", pending_count, 1);
    check_val("t1_nrs_early", new_round_start, 0);
    tick();
    check_val("t1_nrs", new_round_start, 1);
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    tick();
    check_val("t1_nrs_pulse", new_round_start, 0);
    root_finish(39, 8'd3, 32'd40);
    take_report(2'd0, 8'd3, 32'd40, 1'b0);
    check_val("t1_pend0", pending_count, 0);

    // 2: back-pressure with root busy, then drain ids 0..3
    do_reset();
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    round_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("t2_pend", pending_count, (i + 1 < QD) ? i + 1 : QD);
    end
    round_valid = 1'b0;
    check_val("t2_ready0", round_ready, 0);
    global_stage = STAGE_IDLE;
    for (int k = 0; k < 4; k++) begin
      root_serve(10 + k, 8'(k + 5), 32'(100 + k));
      take_report(2'(k), 8'(k + 5), 32'(100 + k), 1'b0);
      check_val("t2_drain", pending_count, 3 - k);
    end

    // 3: timeout at launch+64, no relaunch until root idle
    pulse_round();
    wait_launch();
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    repeat (63) tick();
    check_val("t3_not_yet", report_valid, 0);
    tick();
    check_val("t3_fire", report_valid, 1);
    pulse_round();
    check_val("t3_pend2", pending_count, 2);
    take_report(2'd0, 8'd8, 32'd103, 1'b1);
    check_val("t3_pend1", pending_count, 1);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      saw = saw | new_round_start;
    end
    check_val("t3_no_relaunch", saw, 0);
    global_stage = STAGE_IDLE;
    root_serve(5, 8'd2, 32'd5);
    take_report(2'd1, 8'd2, 32'd5, 1'b0);

    // 4: report stall, record held stable, accept during stall
    pulse_round();
    root_serve(8, 8'd4, 32'd8);
    while (!report_valid) tick();
    held = 1'b1;
    for (int i = 0; i < 20; i++) begin
      round_valid = (i == 5);
      tick();
      held = held & report_valid & (report_iterations == 8'd4) & (report_cycles == 32'd8)
             & (report_round_id == 2'd2);
    end
    round_valid = 1'b0;
    check_val("t4_held", held, 1);
    check_val("t4_pend2", pending_count, 2);
    round_valid  = 1'b1;
    report_ready = 1'b1;
    tick();
    round_valid  = 1'b0;
    report_ready = 1'b0;
    check_val("t4_pend_same", pending_count, 2);
    check_val("t4_rv_drop", report_valid, 0);
    root_serve(6, 8'd1, 32'd6);
    take_report(2'd3, 8'd1, 32'd6, 1'b0);
    root_serve(7, 8'd2, 32'd7);
    take_report(2'd0, 8'd2, 32'd7, 1'b0);
    check_val("t4_pend0", pending_count, 0);

    // 5: reset in S_WAIT discards everything
    pulse_round();
    wait_launch();
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    repeat (5) tick();
    pulse_round();
    check_val("t5_pend2", pending_count, 2);
    reset = 1'b1;
    tick();
    check_val("t5_nrs", new_round_start, 0);
    check_val("t5_rv", report_valid, 0);
    check_val("t5_pend", pending_count, 0);
    check_val("t5_id", report_round_id, 0);
    reset        = 1'b0;
    global_stage = STAGE_IDLE;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      saw = saw | new_round_start;
    end
    check_val("t5_no_launch", saw, 0);
    pulse_round();
    root_serve(4, 8'd9, 32'd4);
    take_report(2'd0, 8'd9, 32'd4, 1'b0);

    // 6: result_rise coincides with watchdog expiry -> not a timeout
    pulse_round();
    wait_launch();
    global_stage = STAGE_DECODE;
    result_valid = 1'b0;
    repeat (63) tick();
    global_stage      = STAGE_IDLE;
    result_valid      = 1'b1;
    iteration_counter = 8'd7;
    cycle_counter     = 32'd63;
    tick();
    check_val("t6_tie_valid", report_valid, 1);
    take_report(2'd1, 8'd7, 32'd63, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
